csa_seq_ctrl: RTL and testbench

CSA_SEQ_CTRL -- requirements
Module: csa_seq_ctrl

---
 rtl/csa_seq_ctrl.sv | 88 ++++++++
 tb/tb_csa_seq_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/csa_seq_ctrl.sv
// csa_seq_ctrl: round-robin sequencer sharing one 4-bit carry-select adder between two requesters
module csa_seq_ctrl #(
   parameter int NIB = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [4*NIB-1:0] a0,
   input  logic [4*NIB-1:0] b0,
   input  logic [4*NIB-1:0] a1,
   input  logic [4*NIB-1:0] b1,
   input  logic             cin0,
   input  logic             cin1,
   output logic [1:0]       gnt,
   output logic [3:0]       add_a,
   output logic [3:0]       add_b,
   output logic             add_cin,
   input  logic [3:0]       add_s,
   input  logic             add_cout,
   output logic [4*NIB-1:0] sum,
   output logic             cout,
   output logic             done,
   output logic             done_id
);
   localparam int W = 4 * NIB;
   localparam int CW = NIB > 1 ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [W-1:0] ra, rb;
   logic [CW-1:0] cnt;
   logic carry, prio, win, accept, run;
   // next state, arbitration and shared-adder drive
   always_comb begin
      state_nx = state;
      win      = (req0 && req1) ? prio : req1;
      accept   = 1'b0;
      run      = state == RUN;
      done     = state == DONE;
      add_a    = run ? ra[{cnt, 2'b00} +: 4] : 4'h0;
      add_b    = run ? rb[{cnt, 2'b00} +: 4] : 4'h0;
      add_cin  = run & carry;
      case (state)
         IDLE: begin
            accept = req0 | req1;
            if (accept) state_nx = RUN;
         end
         RUN: if (cnt == LAST) state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end
   // operand capture, slice-by-slice result assembly and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt     <= 2'b00;
         ra      <= '0;
         rb      <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         done_id <= 1'b0;
         prio    <= 1'b0;
      end else begin
         gnt <= accept ? (win ? 2'b10 : 2'b01) : 2'b00;
         if (accept) begin
            ra      <= win ? a1 : a0;
            rb      <= win ? b1 : b0;
            carry   <= win ? cin1 : cin0;
            cnt     <= '0;
            sum     <= '0;
            done_id <= win;
            prio    <= ~win;
         end else if (run) begin
            sum[{cnt, 2'b00} +: 4] <= add_s;
            carry <= add_cout;
            cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
            if (cnt == LAST) cout <= add_cout;
         end
      end
   end
endmodule

// File: tb/tb_csa_seq_ctrl.sv
// tb_csa_seq_ctrl: randomized scoreboard bench for csa_seq_ctrl with a behavioural shared adder
module tb_csa_seq_ctrl;
   localparam int NIB = 4;
   localparam int W = 4 * NIB;
   logic clk = 1'b0, rst_n = 1'b0, req0 = 1'b0, req1 = 1'b0, cin0 = 1'b0, cin1 = 1'b0;
   logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic [1:0] gnt;
   logic [3:0] add_a, add_b, add_s;
   logic add_cin, add_cout, cout, done, done_id;
   logic [W-1:0] sum;
   typedef struct {logic [W:0] res; logic id; int cyc;} exp_t;
   exp_t sb[$];
   int checks = 0, failures = 0, cyc = 0;
   logic prio_m = 1'b0;

   csa_seq_ctrl #(.NIB(NIB)) dut (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1), .cin0(cin0), .cin1(cin1),
      .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_s(add_s), .add_cout(add_cout),
      .sum(sum), .cout(cout), .done(done), .done_id(done_id)
   );

   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp_v, cyc);
      end
   endtask

   // monitor: every done pulse must match the oldest outstanding expected result
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done_spurious actual=done required=no done at cycle %0d", cyc);
         end else begin
            e = sb.pop_front();
            chk("result", {cout, sum}, e.res);
            chk("done_id", done_id, e.id);
            chk("done_cycle", cyc, e.cyc);
            chk("idle_adder", {add_a, add_b, add_cin}, 0);
         end
      end
   end

   task automatic wait_gnt(output int n);
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (gnt != 2'b00) begin
            n = i;
            break;
         end
      end
      if (n == 0) begin
         checks++;
         failures++;
         $display("FAIL gnt_timeout actual=no grant required=grant within 40 cycles");
      end
   endtask

   // called at the negedge where gnt is seen: predict winner, queue result, walk the slices
   task automatic accepted(input bit abort, output logic w);
      logic [W-1:0] x, y;
      logic c;
      logic [63:0] m, ci;
      exp_t e;
      w = (req0 && req1) ? prio_m : req1;
      prio_m = ~w;
      x = w ? a1 : a0;
      y = w ? b1 : b0;
      c = w ? cin1 : cin0;
      chk("gnt", gnt, w ? 2'b10 : 2'b01);
      e.res = {1'b0, x} + {1'b0, y} + (W + 1)'(c);
      e.id = w;
      e.cyc = cyc + NIB;
      if (!abort) sb.push_back(e);
      for (int k = 0; k < NIB; k++) begin
         if (k > 0) @(negedge clk);
         m = (64'd1 << (4 * k)) - 64'd1;
         ci = ((64'(x) & m) + (64'(y) & m) + 64'(c)) >> (4 * k);
         chk("slice_a", add_a, x[4*k +: 4]);
         chk("slice_b", add_b, y[4*k +: 4]);
         chk("slice_cin", add_cin, ci[0]);
         if (k == 1) chk("gnt_pulse", gnt, 0);
         if (abort && k == 2) begin
            rst_n = 1'b0;
            break;
         end
         a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
         cin0 = 1'($urandom); cin1 = 1'($urandom);
      end
   endtask

   task automatic op(input logic q0, q1, input logic [W-1:0] x0, y0, x1, y1, input logic c0, c1);
      int n;
      logic w;
      a0 = x0; b0 = y0; a1 = x1; b1 = y1; cin0 = c0; cin1 = c1;
      req0 = q0; req1 = q1;
      wait_gnt(n);
      if (n != 0) accepted(1'b0, w);
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain actual=%0d pending required=0 pending", sb.size());
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_done_id", done_id, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_adder", {add_a, add_b, add_cin}, 0);
   endtask

   initial begin
      int n, r, last, g;
      logic w;
      #1;
      chk_reset_outputs();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      // both requesters held right after reset: 01, 10, 01 at NIB+2 spacing
      a0 = 16'h1111; b0 = 16'h2222; a1 = 16'h8888; b1 = 16'h9999; cin0 = 1'b1; cin1 = 1'b0;
      req0 = 1'b1; req1 = 1'b1;
      last = 0;
      for (int i = 0; i < 3; i++) begin
         wait_gnt(n);
         if (n == 0) break;
         g = cyc;
         if (i > 0) chk("gnt_spacing", g - last, NIB + 2);
         last = g;
         accepted(1'b0, w);
         chk("rr_order", w, i % 2);
      end
      req0 = 1'b0; req1 = 1'b0;
      op(1, 0, 16'h0000, 16'hFFFF, 0, 0, 1'b1, 1'b0);
      op(0, 1, 0, 0, 16'h1234, 16'h4321, 1'b0, 1'b0);
      op(1, 0, 16'h0FFF, 16'h0001, 0, 0, 1'b0, 1'b0);
      repeat (40) begin
         r = $urandom_range(1, 3);
         op(r[0], r[1], W'($urandom), W'($urandom), W'($urandom), W'($urandom),
            1'($urandom), 1'($urandom));
      end
      op(1, 0, 16'hFFFF, 16'h0001, 0, 0, 1'b0, 1'b0);
      drain();
      // abort mid-run with reset during slice 2
      a1 = 16'h7777; b1 = 16'h1111; cin1 = 1'b0; req1 = 1'b1;
      wait_gnt(n);
      if (n != 0) accepted(1'b1, w);
      req1 = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      prio_m = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      a0 = 16'hA5A5; b0 = 16'h5A5B; a1 = 16'h0101; b1 = 16'h0202; cin0 = 1'b1; cin1 = 1'b1;
      req0 = 1'b1; req1 = 1'b1;
      wait_gnt(n);
      chk("accept_after_reset", n, 1);
      if (n != 0) accepted(1'b0, w);
      req0 = 1'b0; req1 = 1'b0;
      drain();
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
